// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM state type and statistics record for the SRAM port arbiter.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W     = 18;
    localparam int SRAM_DATA_W     = 16;
    localparam int SRAM_RD_LATENCY = 2;
    localparam int STATS_W         = 96;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } sram_arb_state_type;

    typedef struct packed {
        logic [31:0] grant_cycles;
        logic [31:0] wait_cycles;
        logic [31:0] max_wait;
    } sram_arb_stats_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: the first set request strictly after ptr, cyclically.
// No state, no latency; winner is all-zero when no request is set.
module rr_priority_picker #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any
);

    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;

    // Rotate so that position 0 is the requester just after the pointer.
    always_comb begin
        logic [IDX_W-1:0] src;
        rotated = '0;
        for (int j = 0; j < N; j++) begin
            src        = IDX_W'((int'(ptr) + 1 + j) % N);
            rotated[j] = req[src];
        end
    end

    always_comb begin
        offset = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset = IDX_W'(j);
            end
        end
    end

    assign any = |req;

    always_comb begin
        winner     = '0;
        winner_idx = IDX_W'((int'(ptr) + 1 + int'(offset)) % N);
        if (any) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin, burst-bounded owner of the single SRAM port; grant 1 cycle after req, read data tagged back RD_LATENCY+1 cycles after the access.
// Requesters are throttled by grant only; optional per-requester statistics under SRAM_ARB_STATS_EN.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int MAX_BURST  = 64,
    parameter int RD_LATENCY = SRAM_RD_LATENCY
) (
    input  logic                           Clock,
    input  logic                           Resetn,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*SRAM_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]             req_we_n,
    input  logic [NUM_REQ*SRAM_DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             rdata_valid,
    output logic [SRAM_DATA_W-1:0]         rdata,
    input  logic [SRAM_DATA_W-1:0]         SRAM_read_data,
    output logic [SRAM_ADDR_W-1:0]         SRAM_address,
    output logic [SRAM_DATA_W-1:0]         SRAM_write_data,
    output logic                           SRAM_we_n
`ifdef SRAM_ARB_STATS_EN
    ,
    input  logic                           stats_clr,
    output logic [NUM_REQ*STATS_W-1:0]     stats_flat
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    sram_arb_state_type state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [7:0]         burst_cnt, burst_nxt;

    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] access;
    logic               owner_req;
    logic               burst_full;

    logic [NUM_REQ-1:0] rd_tag_pipe [0:RD_LATENCY-1];

    // While owning, the owner is masked out so the same picker yields the handover target.
    assign pick_req   = (state == ARB_OWN) ? (req & ~grant) : req;
    assign access     = grant & req;
    assign owner_req  = |access;
    assign burst_full = (burst_cnt >= BURST_MAX);

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (pick_req),
        .ptr        (rr_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        burst_nxt  = burst_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nxt  = ARB_OWN;
                    grant_nxt  = pick_onehot;
                    rr_ptr_nxt = pick_idx;
                    burst_nxt  = 8'd1;
                end
            end
            ARB_OWN: begin
                // A drop and a burst-limit revocation take the same handover path.
                if (!owner_req || (burst_full && pick_any)) begin
                    if (pick_any) begin
                        grant_nxt  = pick_onehot;
                        rr_ptr_nxt = pick_idx;
                        burst_nxt  = 8'd1;
                    end else begin
                        state_nxt = ARB_IDLE;
                        grant_nxt = '0;
                        burst_nxt = '0;
                    end
                end else if (!burst_full) begin
                    burst_nxt = burst_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (access[i]) begin
                SRAM_address    = req_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W];
                SRAM_write_data = req_wdata[i*SRAM_DATA_W +: SRAM_DATA_W];
                SRAM_we_n       = req_we_n[i];
            end
        end
    end

    // Tags ride alongside the SRAM latency so returns survive later grant changes.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_tag_pipe[i] <= '0;
            end
            rdata_valid <= '0;
            rdata       <= '0;
        end else begin
            rd_tag_pipe[0] <= access & req_we_n;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_tag_pipe[i] <= rd_tag_pipe[i-1];
            end
            rdata_valid <= rd_tag_pipe[RD_LATENCY-1];
            rdata       <= SRAM_read_data;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    sram_arb_stats_t stats [0:NUM_REQ-1];
    logic [31:0]     cur_wait [0:NUM_REQ-1];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stats[i]    <= '0;
                cur_wait[i] <= '0;
            end
        end else if (stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stats[i]    <= '0;
                cur_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    stats[i].grant_cycles <= sat_inc(stats[i].grant_cycles);
                end
                if (req[i] && !grant[i]) begin
                    stats[i].wait_cycles <= sat_inc(stats[i].wait_cycles);
                    cur_wait[i]          <= sat_inc(cur_wait[i]);
                    if (sat_inc(cur_wait[i]) > stats[i].max_wait) begin
                        stats[i].max_wait <= sat_inc(cur_wait[i]);
                    end
                end else begin
                    cur_wait[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        stats_flat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stats_flat[i*STATS_W +: STATS_W] = stats[i];
        end
    end
`endif

    a_grant_onehot0: assert property (@(posedge Clock) disable iff (!Resetn) $onehot0(grant));
    a_rdata_valid_onehot0: assert property (@(posedge Clock) disable iff (!Resetn) $onehot0(rdata_valid));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed requester scenarios, 2-cycle SRAM model, tagged read returns.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int NR = 3;
    localparam int MB = 4;

    logic              Clock = 1'b0;
    logic              Resetn;
    logic [NR-1:0]     req;
    logic [NR*18-1:0]  req_addr;
    logic [NR-1:0]     req_we_n;
    logic [NR*16-1:0]  req_wdata;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     rdata_valid;
    logic [15:0]       rdata;
    logic [15:0]       SRAM_read_data;
    logic [17:0]       SRAM_address;
    logic [15:0]       SRAM_write_data;
    logic              SRAM_we_n;
`ifdef SRAM_ARB_STATS_EN
    logic              stats_clr;
    logic [NR*96-1:0]  stats_flat;
`endif

    always #5 Clock = ~Clock;

    sram_port_arbiter #(
        .NUM_REQ    (NR),
        .MAX_BURST  (MB),
        .RD_LATENCY (2)
    ) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .req             (req),
        .req_addr        (req_addr),
        .req_we_n        (req_we_n),
        .req_wdata       (req_wdata),
        .grant           (grant),
        .rdata_valid     (rdata_valid),
        .rdata           (rdata),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n)
`ifdef SRAM_ARB_STATS_EN
        ,
        .stats_clr       (stats_clr),
        .stats_flat      (stats_flat)
`endif
    );

    function automatic logic [15:0] rd_fn(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h0A5C} ^ 16'h3C00;
    endfunction

    // SRAM model: data for the address presented two cycles earlier.
    logic [17:0] sram_p1, sram_p2;
    always @(posedge Clock) begin
        sram_p1 <= SRAM_address;
        sram_p2 <= sram_p1;
    end
    assign SRAM_read_data = rd_fn(sram_p2);

    typedef struct {
        int          due;
        logic [NR-1:0] vld;
        logic [15:0] dat;
    } rd_exp_t;

    rd_exp_t       sbq[$];
    logic [NR-1:0] exp_grant[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          wr_seen = 0;
    int          remaining [NR];
    int          start_at [NR];
    int          done [NR];
    logic [17:0] base [NR];
    logic        wr [NR];
    logic [15:0] wdat [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < NR; i++) begin
            req[i]                = (remaining[i] > 0) && (cyc >= start_at[i]);
            req_we_n[i]           = ~wr[i];
            req_addr[i*18 +: 18]  = base[i] + 18'(done[i]);
            req_wdata[i*16 +: 16] = wdat[i];
        end
    endtask

    task automatic monitor();
        logic [17:0]   ea;
        logic [15:0]   ed;
        logic          ew;
        logic [NR-1:0] acc;
        logic [NR-1:0] oh;
        rd_exp_t       e;
        ea  = '0;
        ed  = '0;
        ew  = 1'b1;
        acc = grant & req;
        if (exp_grant.size() > 0) begin
            check("grant", 32'(grant), 32'(exp_grant.pop_front()));
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            check("rdata_valid", 32'(rdata_valid), 32'(e.vld));
            check("rdata", 32'(rdata), 32'(e.dat));
        end else if (rdata_valid != '0) begin
            check("rdata_valid_spurious", 32'(rdata_valid), 32'd0);
        end
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                ea = req_addr[i*18 +: 18];
                ed = req_wdata[i*16 +: 16];
                ew = req_we_n[i];
                if (req_we_n[i]) begin
                    oh    = '0;
                    oh[i] = 1'b1;
                    sbq.push_back('{cyc + 3, oh, rd_fn(req_addr[i*18 +: 18])});
                end else begin
                    wr_seen++;
                end
                remaining[i]--;
                done[i]++;
            end
        end
        check("sram_addr", 32'(SRAM_address), 32'(ea));
        check("sram_wdata", 32'(SRAM_write_data), 32'(ed));
        check("sram_we_n", 32'(SRAM_we_n), 32'(ew));
    endtask

    task automatic step();
        @(negedge Clock);
        monitor();
        @(posedge Clock);
        #1;
        cyc++;
        drive_req();
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sbq.size() > 0; k++) begin
            step();
        end
        check("sb_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        for (int i = 0; i < NR; i++) begin
            remaining[i] = 0;
            start_at[i]  = 0;
            done[i]      = 0;
            base[i]      = '0;
            wr[i]        = 1'b0;
            wdat[i]      = '0;
        end
        cyc     = 0;
        wr_seen = 0;
        sbq.delete();
        exp_grant.delete();
        drive_req();
        repeat (2) @(posedge Clock);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_we_n", 32'(SRAM_we_n), 32'd1);
        check("rst_addr", 32'(SRAM_address), 32'd0);
        Resetn = 1'b1;
    endtask

`ifdef SRAM_ARB_STATS_EN
    task automatic check_stats(input int i, input int g, input int w, input int m);
        sram_arb_stats_t st;
        st = stats_flat[i*96 +: 96];
        check("stat_grant", st.grant_cycles, 32'(g));
        check("stat_wait", st.wait_cycles, 32'(w));
        check("stat_maxwait", st.max_wait, 32'(m));
    endtask
`endif

    initial begin
        Resetn    = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_we_n  = '1;
        req_wdata = '0;
`ifdef SRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        // Single reader: grant at cycle 1, data tagged back at cycle 4.
        do_reset();
        base[1]      = 18'd76802;
        remaining[1] = 1;
        drive_req();
        exp_grant = '{3'b000, 3'b010, 3'b010, 3'b000};
        repeat (4) step();
        drain();

        // Three simultaneous requests, one access each: 0,1,2 with grant never idle between.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            base[i]      = 18'(10 * (i + 1));
            remaining[i] = 1;
        end
        drive_req();
        exp_grant = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000};
        repeat (8) step();
        drain();

        // Burst limit 4: req0 continuous, req2 from cycle 2.
        do_reset();
        base[0]      = 18'h00100;
        remaining[0] = 6;
        base[2]      = 18'h00300;
        remaining[2] = 2;
        start_at[2]  = 2;
        drive_req();
        exp_grant = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100,
                      3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b000};
        repeat (12) step();
        drain();

        // Read by 0 followed by a write from 1.
        do_reset();
        base[0]      = 18'h00200;
        remaining[0] = 1;
        base[1]      = 18'd100;
        wr[1]        = 1'b1;
        wdat[1]      = 16'hABCD;
        remaining[1] = 1;
        drive_req();
        exp_grant = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b000};
        repeat (6) step();
        drain();
        check("write_count", 32'(wr_seen), 32'd1);

        // Reset pulse with reads in flight.
        do_reset();
        base[1]      = 18'h01000;
        remaining[1] = 4;
        drive_req();
        exp_grant = '{3'b000, 3'b010, 3'b010, 3'b010};
        repeat (4) step();
        #2;
        check("pre_rst_grant", 32'(grant), 32'd2);
        check("pre_rst_valid", 32'(rdata_valid), 32'd2);
        Resetn = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_valid", 32'(rdata_valid), 32'd0);
        do_reset();
        repeat (6) begin
            step();
            check("post_rst_valid", 32'(rdata_valid), 32'd0);
            check("post_rst_grant", 32'(grant), 32'd0);
        end

`ifdef SRAM_ARB_STATS_EN
        // Ten cycles of contention between requesters 0 and 1.
        do_reset();
        remaining[0] = 100;
        remaining[1] = 100;
        drive_req();
        repeat (10) step();
        check_stats(0, 5, 5, 4);
        check_stats(1, 4, 6, 5);
        stats_clr    = 1'b1;
        remaining[0] = 0;
        remaining[1] = 0;
        drive_req();
        @(posedge Clock);
        #1;
        stats_clr = 1'b0;
        for (int i = 0; i < NR; i++) begin
            check_stats(i, 0, 0, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
